// File: rtl/nibble_mult_accum.sv
// Control and accumulate stage of the 8x8 sequential multiplier: steers the
// nibble selector over four steps and sums the shifted 4x4 partial products.
module nibble_mult_accum (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [3:0]  aout,
  input  logic [3:0]  bout,
  output logic [1:0]  sel,
  output logic [15:0] product,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  // Handshake: start is sampled as a level only in IDLE; busy is high for the
  // four CALC cycles; done is a one-cycle pulse during which product is final.
  // Starts seen while busy or done are dropped, never queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [1:0]  sel_nxt;
  logic        busy_nxt, done_nxt;
  logic [15:0] acc, acc_nxt;
  logic [7:0]  pp;
  logic [15:0] pp_ext, pp_shifted;

  assign pp     = {4'h0, aout} * {4'h0, bout};
  assign pp_ext = {8'h00, pp};

  // Steps 1 and 2 are the two cross terms (A hi x B lo, A lo x B hi), both weight 16.
  always_comb begin
    pp_shifted = pp_ext;
    case (cnt)
      2'd0:    pp_shifted = pp_ext;
      2'd1:    pp_shifted = pp_ext << 4;
      2'd2:    pp_shifted = pp_ext << 4;
      2'd3:    pp_shifted = pp_ext << 8;
      default: pp_shifted = pp_ext;
    endcase
  end

  // sel, busy and done are computed one cycle ahead and registered so the
  // selector sees clean, edge-aligned controls.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    sel_nxt   = 2'b00;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CALC;
          cnt_nxt   = 2'd0;
          busy_nxt  = 1'b1;
          sel_nxt   = 2'b00;
        end
      end
      CALC: begin
        // Step 0 overwrites the accumulator, so no clear cycle is needed.
        if (cnt == 2'd0) begin
          acc_nxt = pp_shifted;
        end else begin
          acc_nxt = acc + pp_shifted;
        end
        if (cnt == 2'd3) begin
          state_nxt = DONE;
          cnt_nxt   = 2'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt  = cnt + 2'd1;
          busy_nxt = 1'b1;
          sel_nxt  = cnt + 2'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state <= IDLE;
      cnt   <= 2'd0;
      acc   <= 16'h0000;
      sel   <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      sel   <= sel_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  assign product   = acc;
  assign state_dbg = state;

endmodule

// File: doc/nibble_mult_accum.md
# nibble_mult_accum

Sequential datapath and control stage that sits directly downstream of the 4-bit nibble selector (`mux4`) in the 8x8 sequential multiplier. It drives the selector's `sel` lines and accepts the two selected 4-bit nibbles. Each cycle it forms a 4x4 partial product, shifts it to its weight, and accumulates it into a 16-bit register. After four cycles it presents the full 16-bit product of the two 8-bit operands and pulses `done`.

## Interface
- No parameters. Widths are fixed: 4-bit nibbles, 2-bit select, 16-bit product.
- `clk`  in  1  Rising-edge clock.
- `reset_a`  in  1  Asynchronous reset, active-low. Forces every register to its reset value immediately.
- `start`  in  1  Level-sampled request to begin a multiply. Honoured only in IDLE.
- `aout`  in  4  Selected nibble of operand A, from the selector.
- `bout`  in  4  Selected nibble of operand B, from the selector.
- `sel`  out  2  Nibble select to the selector.
  - `sel[0]`=1 selects A[7:4]; `sel[0]`=0 selects A[3:0].
  - `sel[1]`=1 selects B[7:4]; `sel[1]`=0 selects B[3:0].
- `product`  out  16  Accumulator register contents.
- `busy`  out  1  High while in CALC.
- `done`  out  1  Single-cycle pulse; `product` is final while it is high.

## Operation
- FSM states and transitions:
  - IDLE -> CALC when `start`=1. The step counter `cnt` (2 bits) loads 0.
  - CALC -> CALC while `cnt`<3. `cnt` increments on each edge.
  - CALC -> DONE on the edge where `cnt`=3.
  - DONE -> IDLE unconditionally.
- `sel` is registered-state driven:
  - equals `cnt` in CALC;
  - 2'b00 in IDLE and DONE.
- Step order and shift per step:
  - `cnt`=0: sel 00, A lo x B lo, shift 0.
  - `cnt`=1: sel 01, A hi x B lo, shift 4.
  - `cnt`=2: sel 10, A lo x B hi, shift 4.
  - `cnt`=3: sel 11, A hi x B hi, shift 8.
- Partial product:
  - `pp` = `aout` x `bout`, 8 bits unsigned, combinational.
  - Zero-extended to 16 bits before the shift.
- Accumulate on each CALC edge:
  - `cnt`=0: `acc` <= `pp`<<0. This clears the previous result; no separate clear cycle.
  - `cnt`=1..3: `acc` <= `acc` + (`pp`<<shift).
- Overflow: the 16-bit sum never exceeds 255x255 = 65025. No carry-out is produced or needed.
- Holding and idle behaviour:
  - `product` = `acc`. It holds its value in DONE and IDLE until the next multiply's step 0.
  - `start` in CALC or DONE is ignored; there is no queueing.
  - If `start` is held high continuously, a new multiply begins on the edge after DONE -> IDLE.
- Operand stability: upstream must hold the 8-bit operands feeding the selector stable from the `start` sample edge through the last CALC edge. The block does not latch operands.

## Timing
- Reset values (`reset_a`=0, asynchronous):
  - state=IDLE, `cnt`=0, `acc`=16'h0000, `sel`=2'b00, `busy`=0, `done`=0.
- Edge numbering for one multiply:
  - E0: the edge that samples `start`=1 in IDLE.
  - E1..E4: the four accumulate edges (steps 0..3).
  - After E4: state=DONE, `done`=1, `product` final.
  - After E5: state=IDLE, `done`=0.
- Latency: 4 cycles from E0 to final `product`. `done` is high exactly one cycle.
- Throughput: one result per 6 cycles with `start` held high (IDLE, CALC x4, DONE).
- `busy` is high for exactly the 4 CALC cycles (E0 to E4).
- `sel` changes only on clock edges and is glitch-free.
  - The selector path (`sel` -> `aout`/`bout` -> `pp` -> adder) must settle within one clock period.
- Reset asserted mid-CALC:
  - Immediate return to the reset values; no `done` pulse.
  - After release, the block waits in IDLE for `start`.
- Reset released with `start`=1: the first edge after release acts as E0.

## Test plan
- A=8'hFF, B=8'hFF, pulse `start`:
  - `sel` sequence is 00, 01, 10, 11;
  - `product`=16'hFE01 with `done`=1 exactly 4 cycles after E0.
- A=8'hF0, B=8'hA5:
  - `product`=16'h9AB0 (39600).
  - After step 0, `acc`=16'h0000, since A lo=0.
- A=8'h00, B=8'h7E: `product`=16'h0000 and `done` pulses once.
  - Start a second multiply (A=8'h03, B=8'h05): `product`=16'h000F, confirming the step-0 overwrite.
- Pulse `start` again during CALC: it is ignored, still one `done` per accepted start.
  - Hold `start` high: results arrive every 6 cycles.
- Drive `reset_a`=0 after E2: all outputs return to reset values immediately, with no `done`.
  - Release, then A=8'h12, B=8'h34: `product`=16'h03A8.
